// File: rtl/banco_registradores_ctx_pkg.sv
// Shared definitions for the multi-context register file: default sizes,
// link register index, context-engine state encoding and engine op codes.
package banco_regs_pkg;

   localparam int DATA_W_DEF   = 32;
   localparam int ADDR_W_DEF   = 5;
   localparam int NUM_CTX_DEF  = 4;
   localparam int LINK_REG_DEF = 31;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SAVE  = 2'd1,
      ST_CLEAR = 2'd2
   } eng_state_t;

   localparam logic OP_SAVE  = 1'b0;
   localparam logic OP_CLEAR = 1'b1;

endpackage

// File: rtl/banco_registradores_ctx_engine_fsm.sv
// Context engine: streams one register set out (SAVE) or zeroes it (CLEAR),
// one index per cycle, and flags rejected starts and blocked datapath writes.
module ctx_engine_fsm
   import banco_regs_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int CTX_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CTX_W-1:0]  ctx_sel,
   input  logic              eng_start,
   input  logic              eng_op,
   input  logic [CTX_W-1:0]  eng_ctx,
   input  logic              arch_wr,
   input  logic              dump_ready,
   output logic              eng_busy,
   output logic              eng_done,
   output logic              cmd_err,
   output logic              dump_valid,
   output logic              clr_en,
   output logic [ADDR_W-1:0] idx,
   output logic [CTX_W-1:0]  tgt_ctx,
   output logic              wr_block
);

   // One extra bit so the counter never aliases back to 0 at the last index.
   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'((2**ADDR_W) - 1);

   eng_state_t        state_q, state_n;
   logic [ADDR_W:0]   idx_q, idx_n;
   logic [CTX_W-1:0]  ctx_q, ctx_n;
   logic              done_q, done_n;
   logic              err_q, err_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         ctx_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         idx_q   <= idx_n;
         ctx_q   <= ctx_n;
         done_q  <= done_n;
         err_q   <= err_n;
      end
   end

   always_comb begin
      state_n  = state_q;
      idx_n    = idx_q;
      ctx_n    = ctx_q;
      done_n   = 1'b0;
      wr_block = (state_q != ST_IDLE) && arch_wr && (ctx_sel == ctx_q);
      err_n    = wr_block;
      unique case (state_q)
         ST_IDLE: begin
            if (eng_start) begin
               if (eng_ctx == ctx_sel) begin
                  err_n = 1'b1;
               end else begin
                  state_n = (eng_op == OP_CLEAR) ? ST_CLEAR : ST_SAVE;
                  idx_n   = '0;
                  ctx_n   = eng_ctx;
               end
            end
         end
         ST_SAVE: begin
            if (dump_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_n = ST_IDLE;
                  done_n  = 1'b1;
               end else begin
                  idx_n = idx_q + 1'b1;
               end
            end
         end
         ST_CLEAR: begin
            if (idx_q == LAST_IDX) begin
               state_n = ST_IDLE;
               done_n  = 1'b1;
            end else begin
               idx_n = idx_q + 1'b1;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign eng_busy   = (state_q != ST_IDLE);
   assign dump_valid = (state_q == ST_SAVE);
   assign clr_en     = (state_q == ST_CLEAR);
   assign idx        = idx_q[ADDR_W-1:0];
   assign tgt_ctx    = ctx_q;
   assign eng_done   = done_q;
   assign cmd_err    = err_q;

endmodule

// File: rtl/banco_registradores_ctx.sv
// Multi-context register file: NUM_CTX sets, 2 async reads, 1 write + link write,
// plus a save/clear context engine. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module banco_registradores_ctx
   import banco_regs_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int NUM_CTX  = NUM_CTX_DEF,
   parameter int LINK_REG = LINK_REG_DEF,
   parameter int CTX_W    = $clog2(NUM_CTX)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CTX_W-1:0]  ctx_sel,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              link_en,
   input  logic [DATA_W-1:0] link_data,
   input  logic              eng_start,
   input  logic              eng_op,
   input  logic [CTX_W-1:0]  eng_ctx,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [ADDR_W-1:0] dump_idx,
   output logic [DATA_W-1:0] dump_data,
   output logic              eng_busy,
   output logic              eng_done,
   output logic              cmd_err
);

   localparam int              DEPTH    = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);

   logic [DATA_W-1:0] regs [NUM_CTX][DEPTH];

   logic              clr_en;
   logic              wr_block;
   logic [ADDR_W-1:0] eng_idx;
   logic [CTX_W-1:0]  tgt_ctx;
   logic              arch_we;
   logic [ADDR_W-1:0] arch_addr;
   logic [DATA_W-1:0] arch_data;

   ctx_engine_fsm #(
      .ADDR_W (ADDR_W),
      .CTX_W  (CTX_W)
   ) u_engine (
      .clk        (clk),
      .rst        (rst),
      .ctx_sel    (ctx_sel),
      .eng_start  (eng_start),
      .eng_op     (eng_op),
      .eng_ctx    (eng_ctx),
      .arch_wr    (wr_en | link_en),
      .dump_ready (dump_ready),
      .eng_busy   (eng_busy),
      .eng_done   (eng_done),
      .cmd_err    (cmd_err),
      .dump_valid (dump_valid),
      .clr_en     (clr_en),
      .idx        (eng_idx),
      .tgt_ctx    (tgt_ctx),
      .wr_block   (wr_block)
   );

   // Link write has priority over the regular write port; r0 is never written.
   always_comb begin
      arch_addr = link_en ? LINK_IDX : rd_addr;
      arch_data = link_en ? link_data : wr_data;
      arch_we   = !wr_block && (link_en || wr_en) && (arch_addr != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < NUM_CTX; c++) begin
            for (int r = 0; r < DEPTH; r++) begin
               regs[c][r] <= '0;
            end
         end
      end else begin
         if (arch_we) begin
            regs[ctx_sel][arch_addr] <= arch_data;
         end
         // The engine never targets ctx_sel's blocked writes, so no overlap here.
         if (clr_en) begin
            regs[tgt_ctx][eng_idx] <= '0;
         end
      end
   end

`ifdef REGFILE_BYPASS_EN
   always_comb begin
      rs_data = '0;
      rt_data = '0;
      if (rs_addr != '0) begin
         rs_data = (arch_we && !rst && arch_addr == rs_addr) ? arch_data : regs[ctx_sel][rs_addr];
      end
      if (rt_addr != '0) begin
         rt_data = (arch_we && !rst && arch_addr == rt_addr) ? arch_data : regs[ctx_sel][rt_addr];
      end
   end
`else
   always_comb begin
      rs_data = (rs_addr == '0) ? '0 : regs[ctx_sel][rs_addr];
      rt_data = (rt_addr == '0) ? '0 : regs[ctx_sel][rt_addr];
   end
`endif

   assign dump_idx  = eng_idx;
   assign dump_data = dump_valid ? regs[tgt_ctx][eng_idx] : '0;

endmodule

// File: tb/tb_banco_registradores_ctx.sv
// Directed bench for banco_registradores_ctx: arch read/write, link, SAVE with
// back-pressure, CLEAR with write conflict, rejected start, reset mid-SAVE, bypass.
module tb_banco_registradores_ctx;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  ctx_sel;
   logic [4:0]  rs_addr, rt_addr, rd_addr;
   logic [31:0] rs_data, rt_data, wr_data, link_data, dump_data;
   logic        wr_en, link_en, eng_start, eng_op, dump_valid, dump_ready;
   logic [1:0]  eng_ctx;
   logic [4:0]  dump_idx;
   logic        eng_busy, eng_done, cmd_err;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   banco_registradores_ctx dut (
      .clk        (clk),
      .rst        (rst),
      .ctx_sel    (ctx_sel),
      .rs_addr    (rs_addr),
      .rt_addr    (rt_addr),
      .rs_data    (rs_data),
      .rt_data    (rt_data),
      .wr_en      (wr_en),
      .rd_addr    (rd_addr),
      .wr_data    (wr_data),
      .link_en    (link_en),
      .link_data  (link_data),
      .eng_start  (eng_start),
      .eng_op     (eng_op),
      .eng_ctx    (eng_ctx),
      .dump_valid (dump_valid),
      .dump_ready (dump_ready),
      .dump_idx   (dump_idx),
      .dump_data  (dump_data),
      .eng_busy   (eng_busy),
      .eng_done   (eng_done),
      .cmd_err    (cmd_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int k;
      int cyc;
      int cnt;
      rst = 1'b1; ctx_sel = '0; rs_addr = '0; rt_addr = '0; rd_addr = '0;
      wr_en = 0; wr_data = '0; link_en = 0; link_data = '0;
      eng_start = 0; eng_op = 0; eng_ctx = '0; dump_ready = 0;
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("rst_busy", 32'(eng_busy), 0);
      chk("rst_valid", 32'(dump_valid), 0);
      chk("rst_done", 32'(eng_done), 0);
      chk("rst_err", 32'(cmd_err), 0);
      chk("rst_dump_data", dump_data, 0);
      rs_addr = 5;
      for (int c = 0; c < 4; c++) begin
         ctx_sel = 2'(c);
         #1 chk($sformatf("rst_r5_ctx%0d", c), rs_data, 0);
      end

      // Basic write, visible next cycle, other context untouched
      ctx_sel = 0; wr_en = 1; rd_addr = 5; wr_data = 32'hDEADBEEF;
      tick();
      wr_en = 0;
      #1 chk("wr_r5_ctx0", rs_data, 32'hDEADBEEF);
      ctx_sel = 1;
      #1 chk("r5_ctx1", rs_data, 0);

      // r0 is hardwired zero
      ctx_sel = 0; wr_en = 1; rd_addr = 0; wr_data = 32'h1234;
      tick();
      wr_en = 0; rs_addr = 0;
      #1 chk("r0_zero", rs_data, 0);

      // Link write wins over wr_en
      link_en = 1; link_data = 32'h400; wr_en = 1; rd_addr = 7; wr_data = 32'h77;
      tick();
      link_en = 0; wr_en = 0; rs_addr = 31; rt_addr = 7;
      #1 chk("link_r31", rs_data, 32'h400);
      chk("link_r7_untouched", rt_data, 0);

      // Fill ctx2 with i+0x100
      ctx_sel = 2;
      for (int i = 1; i < 32; i++) begin
         wr_en = 1; rd_addr = 5'(i); wr_data = 32'(i) + 32'h100;
         tick();
      end
      wr_en = 0;

      // SAVE ctx2 with ready toggling
      ctx_sel = 0; eng_start = 1; eng_op = 0; eng_ctx = 2;
      tick();
      eng_start = 0;
      chk("save_busy", 32'(eng_busy), 1);
      k = 0; cyc = 0;
      while (k < 32 && cyc < 200) begin
         dump_ready = cyc[0];
         #1;
         chk("save_valid", 32'(dump_valid), 1);
         chk("save_idx", 32'(dump_idx), 32'(k));
         chk("save_data", dump_data, (k == 0) ? 32'h0 : 32'(k) + 32'h100);
         chk("save_no_early_done", 32'(eng_done), 0);
         if (dump_ready && dump_valid) k++;
         tick();
         cyc++;
      end
      dump_ready = 0;
      chk("save_beats", 32'(k), 32);
      chk("save_done", 32'(eng_done), 1);
      chk("save_idle", 32'(eng_busy), 0);
      chk("save_valid_off", 32'(dump_valid), 0);
      tick();
      chk("save_done_pulse", 32'(eng_done), 0);

      // CLEAR ctx1 with conflicting write mid-way
      ctx_sel = 1; wr_en = 1; rd_addr = 3; wr_data = 32'h33;
      tick();
      wr_en = 0; ctx_sel = 0; eng_start = 1; eng_op = 1; eng_ctx = 1;
      tick();
      eng_start = 0;
      cnt = 0;
      while (eng_busy && cnt < 100) begin
         if (cnt == 5) begin
            ctx_sel = 1; wr_en = 1; rd_addr = 3; wr_data = 32'h99;
         end else begin
            ctx_sel = 0; wr_en = 0;
         end
         tick();
         cnt++;
         if (cnt == 6) chk("clear_conflict_err", 32'(cmd_err), 1);
      end
      wr_en = 0;
      chk("clear_cycles", 32'(cnt), 32);
      chk("clear_done", 32'(eng_done), 1);
      ctx_sel = 1;
      for (int i = 0; i < 32; i++) begin
         rs_addr = 5'(i);
         #1 chk($sformatf("clear_r%0d", i), rs_data, 0);
      end
      ctx_sel = 0; rs_addr = 5;
      #1 chk("clear_ctx0_kept", rs_data, 32'hDEADBEEF);

      // Start on the active context is rejected
      ctx_sel = 2; eng_start = 1; eng_op = 0; eng_ctx = 2;
      tick();
      eng_start = 0;
      chk("rej_err", 32'(cmd_err), 1);
      chk("rej_busy", 32'(eng_busy), 0);
      tick();
      chk("rej_err_pulse", 32'(cmd_err), 0);

      // Reset at beat 10 of SAVE
      ctx_sel = 0; eng_start = 1; eng_op = 0; eng_ctx = 2;
      tick();
      eng_start = 0; dump_ready = 1;
      for (int i = 0; i < 10; i++) tick();
      chk("rst_mid_idx", 32'(dump_idx), 10);
      chk("rst_mid_data", dump_data, 32'h10A);
      rst = 1;
      tick();
      rst = 0; dump_ready = 0;
      chk("rst_mid_valid", 32'(dump_valid), 0);
      chk("rst_mid_busy", 32'(eng_busy), 0);
      chk("rst_mid_done", 32'(eng_done), 0);
      tick();
      chk("rst_mid_done2", 32'(eng_done), 0);
      ctx_sel = 2; rs_addr = 10;
      #1 chk("rst_mid_ctx2_cleared", rs_data, 0);

      // Same-cycle read of a write
      ctx_sel = 0; wr_en = 1; rd_addr = 9; wr_data = 32'hA5A5; rs_addr = 9;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("bypass_same_cycle", rs_data, 32'hA5A5);
`else
      chk("bypass_same_cycle", rs_data, 0);
`endif
      tick();
      wr_en = 0;
      #1 chk("bypass_next_cycle", rs_data, 32'hA5A5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
